// File: rtl/counter_display_mux.sv
// N-digit hex/BCD up/down counter driving a multiplexed common-cathode 7-segment display.
// Build macro LEADING_ZERO_BLANK_EN blanks leading-zero digits above digit 0.
module counter_display_mux #(
    parameter int DIGITS    = 4,
    parameter int BCD       = 0,
    parameter int COUNT_DIV = 25_000_000,
    parameter int SCAN_DIV  = 50_000
) (
    input  logic              clk50MHz,
    input  logic              rst,
    input  logic              en,
    input  logic              up,
    output logic [6:0]        Segments,
    output logic              dp,
    output logic [DIGITS-1:0] Digits
);
    localparam int CW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VW = 4 * DIGITS;
    localparam logic [3:0] DMAX = (BCD != 0) ? 4'd9 : 4'd15;

    logic [CW-1:0]     cnt_div_q, cnt_div_d;
    logic [SW-1:0]     scan_div_q, scan_div_d;
    logic [IW-1:0]     scan_idx_q, scan_idx_d;
    logic [VW-1:0]     value_q, value_d;
    logic              cnt_tick, scan_tick;
    logic [3:0]        sel_nib;
    logic [6:0]        seg_d;
    logic              dp_d;
    logic [DIGITS-1:0] digits_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: seg_decode = 7'h3F;
            4'h1: seg_decode = 7'h06;
            4'h2: seg_decode = 7'h5B;
            4'h3: seg_decode = 7'h4F;
            4'h4: seg_decode = 7'h66;
            4'h5: seg_decode = 7'h6D;
            4'h6: seg_decode = 7'h7D;
            4'h7: seg_decode = 7'h07;
            4'h8: seg_decode = 7'h7F;
            4'h9: seg_decode = 7'h6F;
            4'hA: seg_decode = 7'h77;
            4'hB: seg_decode = 7'h7C;
            4'hC: seg_decode = 7'h39;
            4'hD: seg_decode = 7'h5E;
            4'hE: seg_decode = 7'h79;
            default: seg_decode = 7'h71;
        endcase
    endfunction

    assign cnt_tick   = (cnt_div_q == CW'(COUNT_DIV - 1));
    assign cnt_div_d  = cnt_tick ? '0 : cnt_div_q + CW'(1);
    assign scan_tick  = (scan_div_q == SW'(SCAN_DIV - 1));
    assign scan_div_d = scan_tick ? '0 : scan_div_q + SW'(1);
    assign scan_idx_d = !scan_tick ? scan_idx_q :
                        (scan_idx_q == IW'(DIGITS - 1)) ? '0 : scan_idx_q + IW'(1);

    // Carry/borrow ripples from digit 0 upward within a single cycle.
    always_comb begin
        logic       carry;
        logic [3:0] nib;
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        value_d = value_q;
        carry   = cnt_tick & en;
        nib     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib = value_q[4*i +: 4];
            if (carry) begin
                if (up) begin
                    if (nib == DMAX) begin
                        nib = '0;
                    end else begin
                        nib   = nib + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (nib == 4'd0) begin
                        nib = DMAX;
                    end else begin
                        nib   = nib - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            value_d[4*i +: 4] = nib;
        end
    end

    // Outputs load from the next scan index and the current value so select and data always agree.
    always_comb begin
        sel_nib  = '0;
        digits_d = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx_d == IW'(i)) begin
                sel_nib     = value_q[4*i +: 4];
                digits_d[i] = 1'b0;
            end
        end
        seg_d = seg_decode(sel_nib);
        if ((BCD != 0) && (sel_nib > 4'd9)) begin
            seg_d = 7'h00;
        end
`ifdef LEADING_ZERO_BLANK_EN
        if ((scan_idx_d != '0) && ((value_q >> {scan_idx_d, 2'b00}) == '0)) begin
            seg_d = 7'h00;
        end
`endif
        dp_d = (scan_idx_d == '0) && value_q[0];
    end

    always_ff @(posedge clk50MHz or posedge rst) begin
        if (rst) begin
            cnt_div_q  <= '0;
            scan_div_q <= '0;
            scan_idx_q <= '0;
            value_q    <= '0;
            Segments   <= 7'h00;
            dp         <= 1'b0;
            Digits     <= '1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            cnt_div_q  <= cnt_div_d;
            scan_div_q <= scan_div_d;
            scan_idx_q <= scan_idx_d;
            value_q    <= value_d;
            Segments   <= seg_d;
            dp         <= dp_d;
            Digits     <= digits_d;
        end
    end
endmodule

// File: tb/tb_counter_display_mux.sv
// Self-checking bench: hex and BCD instances side by side against an arithmetic reference model.
module tb_counter_display_mux;
    localparam int DIGITS    = 4;
    localparam int COUNT_DIV = 8;
    localparam int SCAN_DIV  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       up  = 1'b1;
    logic [6:0] seg_h, seg_b;
    logic       dp_h, dp_b;
    logic [3:0] dig_h, dig_b;

    int checks = 0;
    int errors = 0;
    int k      = 0;
    int val_h  = 0;
    int val_b  = 0;
    logic [23:0] exp_v;
    logic [23:0] act;

    always #5 clk = ~clk;
    assign act = {dig_h, seg_h, dp_h, dig_b, seg_b, dp_b};

    counter_display_mux #(.DIGITS(DIGITS), .BCD(0), .COUNT_DIV(COUNT_DIV), .SCAN_DIV(SCAN_DIV)) u_hex (
        .clk50MHz(clk), .rst(rst), .en(en), .up(up),
        .Segments(seg_h), .dp(dp_h), .Digits(dig_h)
    );

    counter_display_mux #(.DIGITS(DIGITS), .BCD(1), .COUNT_DIV(COUNT_DIV), .SCAN_DIV(SCAN_DIV)) u_bcd (
        .clk50MHz(clk), .rst(rst), .en(en), .up(up),
        .Segments(seg_b), .dp(dp_b), .Digits(dig_b)
    );

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return tbl[d];
    endfunction

    function automatic int ipow(input int b, input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    // Expected {Digits, Segments, dp} for one displayed slot of an integer count in the given radix.
    function automatic logic [11:0] model_out(input int val, input int base, input int idx);
        logic [3:0] d = 4'b1111;
        logic [6:0] s;
        logic       p;
        int         upper;
        upper  = val / ipow(base, idx);
        s      = seg_of(upper % base);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0 && upper == 0) s = 7'h00;
`endif
        p      = (idx == 0) && (val % 2 == 1);
        d[idx] = 1'b0;
        return {d, s, p};
    endfunction

    // Advance one clock edge and the model; exp_v holds what the outputs must show after this edge.
    task automatic step();
        logic en_s, up_s;
        int   idx;
        en_s = en;
        up_s = up;
        @(posedge clk);
        #1;
        k++;
        idx   = (k / SCAN_DIV) % DIGITS;
        exp_v = {model_out(val_h, 16, idx), model_out(val_b, 10, idx)};
        if ((k % COUNT_DIV == 0) && en_s) begin
            val_h = up_s ? (val_h + 1) % 65536 : (val_h + 65535) % 65536;
            val_b = up_s ? (val_b + 1) % 10000 : (val_b + 9999) % 10000;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        k     = 0;
        val_h = 0;
        val_b = 0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++;
        if (act !== {4'hF, 7'h00, 1'b0, 4'hF, 7'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold: got %h want %h", act, {4'hF, 7'h00, 1'b0, 4'hF, 7'h00, 1'b0});
        end
        rst = 1'b0;
        k   = 0;
        step();
        checks++;
        if (dig_h !== 4'b1110 || seg_h !== 7'h3F || dig_b !== 4'b1110 || seg_b !== 7'h3F) begin
            errors++;
            $display("FAIL reset_release: got dig %b seg %h want dig 1110 seg 3f", dig_h, seg_h);
        end
        en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL reset_run k=%0d: got %h want %h", k, act, exp_v);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (act !== {4'hF, 7'h00, 1'b0, 4'hF, 7'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_async: got %h want %h", act, {4'hF, 7'h00, 1'b0, 4'hF, 7'h00, 1'b0});
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        k     = 0;
        val_h = 0;
        val_b = 0;
        step();
        checks++;
        if (dig_h !== 4'b1110 || seg_h !== 7'h3F || act !== exp_v) begin
            errors++;
            $display("FAIL reset_rerelease: got %h want %h", act, exp_v);
        end
    endtask

    task automatic test_hex_up();
        do_reset();
        en = 1'b1;
        up = 1'b1;
        for (int i = 0; i < 140; i++) begin
            step();
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL hex_up k=%0d: got %h want %h", k, act, exp_v);
            end
            if (k == 128) begin
                checks++;
                if (seg_h !== 7'h71 || dig_h !== 4'b1110) begin
                    errors++;
                    $display("FAIL hex_up_F: got seg %h dig %b want seg 71 dig 1110", seg_h, dig_h);
                end
            end
            if (k == 129) begin
                checks++;
                if (seg_h !== 7'h3F) begin
                    errors++;
                    $display("FAIL hex_up_d0_after_carry: got %h want 3f", seg_h);
                end
            end
            if (k == 132) begin
                checks++;
                if (seg_h !== 7'h06 || dig_h !== 4'b1101) begin
                    errors++;
                    $display("FAIL hex_up_carry_d1: got seg %h dig %b want seg 06 dig 1101", seg_h, dig_h);
                end
            end
        end
    endtask

    task automatic test_down_wrap();
        do_reset();
        en = 1'b1;
        up = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (k == 8) en = 1'b0;
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL down_wrap k=%0d: got %h want %h", k, act, exp_v);
            end
            if (k > 8) begin
                checks++;
                if (seg_h !== 7'h71 || seg_b !== 7'h6F) begin
                    errors++;
                    $display("FAIL down_wrap_max k=%0d: got hex %h bcd %h want 71 6f", k, seg_h, seg_b);
                end
            end
        end
    endtask

    task automatic test_up_wrap();
        logic [6:0] want;
        en = 1'b1;
        up = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step();
            if (k == 32) en = 1'b0;
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL up_wrap k=%0d: got %h want %h", k, act, exp_v);
            end
            if (k > 32) begin
                want = 7'h3F;
`ifdef LEADING_ZERO_BLANK_EN
                if ((k / SCAN_DIV) % DIGITS != 0) want = 7'h00;
`endif
                checks++;
                if (seg_h !== want || seg_b !== want) begin
                    errors++;
                    $display("FAIL up_wrap_zero k=%0d: got hex %h bcd %h want %h", k, seg_h, seg_b, want);
                end
            end
        end
    endtask

    task automatic test_hold_dp();
        logic want_dp;
        en = 1'b1;
        up = 1'b1;
        for (int i = 0; i < 48; i++) begin
            step();
            if (k == 56) en = 1'b0;
            if (k > 56) up = 1'($urandom);
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL hold k=%0d: got %h want %h", k, act, exp_v);
            end
            if (k > 56) begin
                want_dp = ((k / SCAN_DIV) % DIGITS == 0);
                checks++;
                if (dp_h !== want_dp || dp_b !== want_dp) begin
                    errors++;
                    $display("FAIL hold_dp k=%0d: got %b %b want %b", k, dp_h, dp_b, want_dp);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            en = ($urandom % 4) != 0;
            up = 1'($urandom);
            step();
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL random k=%0d: got %h want %h", k, act, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hex_up();
        test_down_wrap();
        test_up_wrap();
        test_hold_dp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
